// File: rtl/led_seq_pkg.sv
// Shared state encoding, default parameters and width helper for the
// sequential multi-channel LED blinker.
package led_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  localparam int TICK_DIV_DEF = 50_000_000;
  localparam int N_CH_DEF     = 2;
  localparam int PULSES_DEF   = 10;

  // Channel-index width; a single channel still needs one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/led_seq_blink_tick_gen.sv
// Free-running prescaler: emits a one-cycle tick every TICK_DIV enabled cycles.
// clr restarts the phase and suppresses the tick on that edge.
module tick_gen #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int            CW   = $clog2(TICK_DIV);
  localparam logic [CW-1:0] TERM = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next-count and tick decode.
  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = {CW{1'b0}};
    end else if (en) begin
      if (cnt_q == TERM) begin
        cnt_d = {CW{1'b0}};
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Prescaler register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {CW{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/led_seq_blink.sv
// Sequential LED blinker: each channel in turn gives PULSES on/off pulses,
// then the sequence stops with a done pulse or wraps when loop_en is high.
module led_seq_blink
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int N_CH     = N_CH_DEF,
  parameter int PULSES   = PULSES_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     en,
  input  logic                     loop_en,
  output logic [N_CH-1:0]          led,
  output logic [ch_w(N_CH)-1:0]    active_ch,
  output logic                     busy,
  output logic                     done
);

  localparam int            AW     = ch_w(N_CH);
  localparam int            TW     = $clog2(2 * PULSES + 1);
  localparam logic [TW-1:0] T_LAST = TW'(2 * PULSES);
  localparam logic [AW-1:0] A_LAST = AW'(N_CH - 1);

  state_e          state_q, state_d;
  logic [TW-1:0]   tcnt_q, tcnt_d, tcnt_inc_s;
  logic [AW-1:0]   ach_q, ach_d;
  logic [N_CH-1:0] led_q, led_d;
  logic            done_q, done_d;
  logic            tick_s;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk  (clk),
    .rst  (rst),
    .clr  (start),
    .en   (en && (state_q == ST_RUN)),
    .tick (tick_s)
  );

  // Sequencer next-state: start overrides any tick on the same edge.
  always_comb begin
    tcnt_inc_s = tcnt_q + TW'(1);
    state_d    = state_q;
    tcnt_d     = tcnt_q;
    ach_d      = ach_q;
    led_d      = led_q;
    done_d     = 1'b0;
    if (start) begin
      state_d = ST_RUN;
      tcnt_d  = {TW{1'b0}};
      ach_d   = {AW{1'b0}};
      led_d   = {N_CH{1'b0}};
    end else if ((state_q == ST_RUN) && tick_s) begin
      led_d[ach_q] = ~led_q[ach_q];
      if (tcnt_inc_s == T_LAST) begin
        tcnt_d = {TW{1'b0}};
        led_d  = {N_CH{1'b0}};
        if (ach_q == A_LAST) begin
          ach_d = {AW{1'b0}};
          if (loop_en) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end
        end else begin
          ach_d = ach_q + AW'(1);
        end
      end else begin
        tcnt_d = tcnt_inc_s;
      end
    end else begin
      state_d = state_q;
    end
  end

  // Sequencer state and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      tcnt_q  <= {TW{1'b0}};
      ach_q   <= {AW{1'b0}};
      led_q   <= {N_CH{1'b0}};
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tcnt_q  <= tcnt_d;
      ach_q   <= ach_d;
      led_q   <= led_d;
      done_q  <= done_d;
    end
  end

  assign led       = led_q;
  assign active_ch = ach_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = done_q;

endmodule

// File: tb/tb_led_seq_blink.sv
// Scoreboard bench for led_seq_blink (TICK_DIV=4, N_CH=3, PULSES=2): expected
// output changes are queued at stimulus time and matched by a negedge monitor.
module tb_led_seq_blink;

  localparam int BIG = 32'h3fff_ffff;

  logic       clk = 1'b0;
  logic       clk_run = 1'b0;
  logic       rst, start, en, loop_en;
  logic [2:0] led;
  logic [1:0] active_ch;
  logic       busy, done;

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } ev_t;

  ev_t        exp_q[$];
  int         cyc = 0;
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;
  logic [6:0] prev;
  wire  [6:0] cur = {led, active_ch, busy, done};

  led_seq_blink #(.TICK_DIV(4), .N_CH(3), .PULSES(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .en        (en),
    .loop_en   (loop_en),
    .led       (led),
    .active_ch (active_ch),
    .busy      (busy),
    .done      (done)
  );

  always #5 if (clk_run) clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Every change of the observable tuple must match the next queued event.
  always @(negedge clk) begin
    ev_t e;
    if (mon_en && (cur !== prev)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL mon_unexpected cyc=%0d got=%b required=no change", cyc, cur);
      end else begin
        e = exp_q.pop_front();
        if ((e.cyc != cyc) || (e.v !== cur)) begin
          errors++;
          $display("FAIL mon_event got cyc=%0d val=%b required cyc=%0d val=%b",
                   cyc, cur, e.cyc, e.v);
        end
      end
    end
    prev = cur;
  end

  task automatic chk(input string nm, input logic [6:0] got, input logic [6:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%b required=%b", nm, got, want);
    end
  endtask

  task automatic push(input int c, input logic [2:0] l, input logic [1:0] a,
                      input logic b, input logic d);
    ev_t e;
    e.cyc = c;
    e.v   = {l, a, b, d};
    exp_q.push_back(e);
  endtask

  // Tick k of channel ch lands 16*ch+4*k edges after start; edges at or after
  // fr_at slip by fr_len; events at or after stop_at are not expected.
  task automatic push_run(input int s, input int fr_at, input int fr_len,
                          input int passes, input int stop_at);
    push(s, 3'b000, 2'd0, 1'b1, 1'b0);
    for (int p = 0; p < passes; p++)
      for (int ch = 0; ch < 3; ch++)
        for (int k = 1; k <= 4; k++) begin
          int         e;
          logic [2:0] on;
          e  = s + 48 * p + 16 * ch + 4 * k;
          if ((fr_len > 0) && (e >= fr_at)) e += fr_len;
          on = 3'b001 << ch;
          if (e < stop_at) begin
            if ((ch == 2) && (k == 4) && (p == passes - 1)) begin
              push(e, 3'b000, 2'd0, 1'b0, 1'b1);
              push(e + 1, 3'b000, 2'd0, 1'b0, 1'b0);
            end else if (k == 4) begin
              push(e, 3'b000, 2'((ch == 2) ? 0 : ch + 1), 1'b1, 1'b0);
            end else begin
              push(e, ((k % 2) == 1) ? on : 3'b000, 2'(ch), 1'b1, 1'b0);
            end
          end
        end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic issue_start(output int s);
    @(negedge clk);
    start = 1'b1;
    s     = cyc + 1;
  endtask

  task automatic drain(input string nm, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0) && (n < budget)) begin
      @(negedge clk);
      n++;
    end
    repeat (4) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending got=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    int s;
    rst = 1'b0; start = 1'b0; en = 1'b1; loop_en = 1'b0;

    // 1: async reset with clock stopped, then quiet idle.
    #3 rst = 1'b1;
    #1 chk("reset_async", cur, 7'b0000000);
    clk_run = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (100) @(negedge clk);
    chk("idle_100", cur, 7'b0000000);

    // 2: single non-looping pass.
    issue_start(s);
    push_run(s, 0, 0, 1, BIG);
    @(negedge clk); start = 1'b0;
    drain("t2_pass", 80);
    chk("t2_done_hold", cur, 7'b0000000);

    // 3: loop for three passes, then let it finish.
    loop_en = 1'b1;
    issue_start(s);
    push_run(s, 0, 0, 3, BIG);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 100);
    loop_en = 1'b0;
    drain("t3_loop", 100);

    // 4: en low for 10 edges starting at s+6.
    issue_start(s);
    push_run(s, s + 6, 10, 1, BIG);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 5);  en = 1'b0;
    wait_cyc(s + 10); chk("t4_frozen", cur, {3'b001, 2'd0, 1'b1, 1'b0});
    wait_cyc(s + 15); en = 1'b1;
    drain("t4_freeze", 80);

    // 5: restart on a tick edge while channel 1 is active.
    issue_start(s);
    push_run(s, 0, 0, 1, s + 20);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 19);
    start = 1'b1;
    push_run(s + 20, 0, 0, 1, BIG);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 22); chk("t5_no_toggle", cur, {3'b000, 2'd0, 1'b1, 1'b0});
    drain("t5_restart", 80);

    // 6: async reset mid-run on channel 2, then a full sequence.
    issue_start(s);
    push_run(s, 0, 0, 1, s + 38);
    @(negedge clk); start = 1'b0;
    wait_cyc(s + 37);
    chk("t6_pre_reset", cur, {3'b100, 2'd2, 1'b1, 1'b0});
    #2;
    mon_en = 1'b0;
    rst    = 1'b1;
    #1 chk("t6_reset_async", cur, 7'b0000000);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL t6_pending got=%0d required=0", exp_q.size());
      exp_q.delete();
    end
    @(negedge clk); rst = 1'b0;
    @(negedge clk); mon_en = 1'b1;
    issue_start(s);
    push_run(s, 0, 0, 1, BIG);
    @(negedge clk); start = 1'b0;
    drain("t6_after_reset", 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running required=finished");
    $fatal(1);
  end

endmodule
